// File: rtl/id_ex_stage.sv
// id_ex_stage -- ID/EX pipeline register and ALU operand-select stage.
//
// Holds one decoded instruction between decode and execute. On its way to
// the ALU the instruction picks up forwarded results from MEM and WB.
// Detects load-use (and, without forwarding, every RAW) hazards and inserts
// bubbles. A branch redirect flushes the stage.
//
// Optional feature macro: FORWARDING_EN
//   defined   : MEM/WB bypass muxes in front of the ALU; stall only on load-use.
//   undefined : operands come straight from the stage register, mem_*/wb_*
//               are ignored, and any RAW dependency on EX stalls.
//
// Ports
//   clk, rst               clock (rising edge), async active-high reset
//   id_*                   decoded instruction fields entering the stage
//   flush                  squash the instruction entering EX
//   mem_*, wb_*            bypass sources from EX/MEM and MEM/WB
//   ALUctrl/ALUop1/ALUop2  ALU opcode and operands
//   ex_store_data          forwarded rs2 value for stores
//   ex_valid/ex_reg_write/ex_mem_read/ex_rd_addr  EX-stage control
//   hazard_stall           stall PC and IF/ID this cycle
module id_ex_stage #(
  parameter int D_WIDTH = 32,
  parameter int A_WIDTH = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [A_WIDTH-1:0] id_rs1_addr,
  input  logic [A_WIDTH-1:0] id_rs2_addr,
  input  logic [A_WIDTH-1:0] id_rd_addr,
  input  logic [D_WIDTH-1:0] id_rs1_data,
  input  logic [D_WIDTH-1:0] id_rs2_data,
  input  logic [D_WIDTH-1:0] id_imm,
  input  logic               id_alu_src,
  input  logic [2:0]         id_alu_ctrl,
  input  logic               id_reg_write,
  input  logic               id_mem_read,
  input  logic               flush,
  input  logic [A_WIDTH-1:0] mem_rd_addr,
  input  logic               mem_reg_write,
  input  logic [D_WIDTH-1:0] mem_result,
  input  logic [A_WIDTH-1:0] wb_rd_addr,
  input  logic               wb_reg_write,
  input  logic [D_WIDTH-1:0] wb_result,
  output logic [2:0]         ALUctrl,
  output logic [D_WIDTH-1:0] ALUop1,
  output logic [D_WIDTH-1:0] ALUop2,
  output logic [D_WIDTH-1:0] ex_store_data,
  output logic               ex_valid,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic [A_WIDTH-1:0] ex_rd_addr,
  output logic               hazard_stall
);

  logic               valid_p1;
  logic [A_WIDTH-1:0] rs1_addr_p1;
  logic [A_WIDTH-1:0] rs2_addr_p1;
  logic [A_WIDTH-1:0] rd_addr_p1;
  logic [D_WIDTH-1:0] rs1_data_p1;
  logic [D_WIDTH-1:0] rs2_data_p1;
  logic [D_WIDTH-1:0] imm_p1;
  logic               alu_src_p1;
  logic [2:0]         alu_ctrl_p1;
  logic               reg_write_p1;
  logic               mem_read_p1;

  logic               src_match;
  logic [D_WIDTH-1:0] fwd1;
  logic [D_WIDTH-1:0] fwd2;

`ifdef FORWARDING_EN
  // MEM is younger than WB, so it wins; x0 is hard-wired and never bypassed.
  function automatic logic [D_WIDTH-1:0] fwd_sel(
    input logic [A_WIDTH-1:0] src_addr,
    input logic [D_WIDTH-1:0] reg_data,
    input logic [A_WIDTH-1:0] m_addr,
    input logic               m_we,
    input logic [D_WIDTH-1:0] m_data,
    input logic [A_WIDTH-1:0] w_addr,
    input logic               w_we,
    input logic [D_WIDTH-1:0] w_data
  );
    if (m_we && (m_addr != '0) && (m_addr == src_addr))
      return m_data;
    else if (w_we && (w_addr != '0) && (w_addr == src_addr))
      return w_data;
    else
      return reg_data;
  endfunction

  assign fwd1 = fwd_sel(rs1_addr_p1, rs1_data_p1, mem_rd_addr, mem_reg_write,
                        mem_result, wb_rd_addr, wb_reg_write, wb_result);
  assign fwd2 = fwd_sel(rs2_addr_p1, rs2_data_p1, mem_rd_addr, mem_reg_write,
                        mem_result, wb_rd_addr, wb_reg_write, wb_result);
`else
  assign fwd1 = rs1_data_p1;
  assign fwd2 = rs2_data_p1;
`endif

  // Both sources are compared even if the opcode does not use rs2 (conservative).
  assign src_match = ex_valid && (ex_rd_addr != '0) && id_valid &&
                     ((ex_rd_addr == id_rs1_addr) || (ex_rd_addr == id_rs2_addr));

`ifdef FORWARDING_EN
  assign hazard_stall = src_match && ex_mem_read;
`else
  // Without bypassing, any in-flight writer of a source must drain first.
  assign hazard_stall = src_match && (ex_mem_read || ex_reg_write);
`endif

  // ---- ID -> EX stage register; flush and stall both load a bubble ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_p1     <= 1'b0;
      rs1_addr_p1  <= '0;
      rs2_addr_p1  <= '0;
      rd_addr_p1   <= '0;
      rs1_data_p1  <= '0;
      rs2_data_p1  <= '0;
      imm_p1       <= '0;
      alu_src_p1   <= 1'b0;
      alu_ctrl_p1  <= '0;
      reg_write_p1 <= 1'b0;
      mem_read_p1  <= 1'b0;
    end else if (flush || hazard_stall) begin
      valid_p1     <= 1'b0;
      rs1_addr_p1  <= '0;
      rs2_addr_p1  <= '0;
      rd_addr_p1   <= '0;
      rs1_data_p1  <= '0;
      rs2_data_p1  <= '0;
      imm_p1       <= '0;
      alu_src_p1   <= 1'b0;
      alu_ctrl_p1  <= '0;
      reg_write_p1 <= 1'b0;
      mem_read_p1  <= 1'b0;
    end else begin
      valid_p1     <= id_valid;
      rs1_addr_p1  <= id_rs1_addr;
      rs2_addr_p1  <= id_rs2_addr;
      rd_addr_p1   <= id_rd_addr;
      rs1_data_p1  <= id_rs1_data;
      rs2_data_p1  <= id_rs2_data;
      imm_p1       <= id_imm;
      alu_src_p1   <= id_alu_src;
      alu_ctrl_p1  <= id_alu_ctrl;
      reg_write_p1 <= id_reg_write;
      mem_read_p1  <= id_mem_read;
    end
  end

  // ---- EX-side operand select ----
  assign ALUctrl       = alu_ctrl_p1;
  assign ALUop1        = fwd1;
  assign ALUop2        = alu_src_p1 ? imm_p1 : fwd2;
  assign ex_store_data = fwd2;
  assign ex_valid      = valid_p1;
  // Gate control with valid so an invalid slot can never write or load.
  assign ex_reg_write  = valid_p1 && reg_write_p1;
  assign ex_mem_read   = valid_p1 && mem_read_p1;
  assign ex_rd_addr    = rd_addr_p1;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic        id_alu_src;
  logic [2:0]  id_alu_ctrl;
  logic        id_reg_write, id_mem_read, flush;
  logic [4:0]  mem_rd_addr, wb_rd_addr;
  logic        mem_reg_write, wb_reg_write;
  logic [31:0] mem_result, wb_result;
  logic [2:0]  ALUctrl;
  logic [31:0] ALUop1, ALUop2, ex_store_data;
  logic        ex_valid, ex_reg_write, ex_mem_read;
  logic [4:0]  ex_rd_addr;
  logic        hazard_stall;

  int n_checks = 0;
  int n_fails  = 0;

  id_ex_stage #(.D_WIDTH(32), .A_WIDTH(5)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rd_addr(id_rd_addr), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_alu_src(id_alu_src), .id_alu_ctrl(id_alu_ctrl),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
    .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .ALUctrl(ALUctrl), .ALUop1(ALUop1), .ALUop2(ALUop2), .ex_store_data(ex_store_data),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_rd_addr(ex_rd_addr), .hazard_stall(hazard_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] imm, input logic src, input logic [2:0] ctrl,
                        input logic rw, input logic mr);
    id_valid = v; id_rs1_addr = r1; id_rs2_addr = r2; id_rd_addr = rd;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_alu_src = src;
    id_alu_ctrl = ctrl; id_reg_write = rw; id_mem_read = mr;
  endtask

  task automatic clr_bypass();
    mem_rd_addr = '0; mem_reg_write = 1'b0; mem_result = '0;
    wb_rd_addr = '0; wb_reg_write = 1'b0; wb_result = '0;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    clr_bypass();
    set_id(1'b1, 5'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom,
           $urandom, 1'($urandom), 3'($urandom), 1'b1, 1'b1);
    #1;
    chk("async_rst_ex_valid", 32'(ex_valid), 32'd0);
    step(); step();
    chk("rst_aluctrl", 32'(ALUctrl), 32'd0);
    chk("rst_op1", ALUop1, 32'd0);
    chk("rst_op2", ALUop2, 32'd0);
    chk("rst_store", ex_store_data, 32'd0);
    chk("rst_regwrite", 32'(ex_reg_write), 32'd0);
    chk("rst_stall", 32'(hazard_stall), 32'd0);

    // Release reset, capture sub x10, x1, x2
    rst = 1'b0;
    set_id(1'b1, 5'd1, 5'd2, 5'd10, 32'd7, 32'd3, 32'h0, 1'b0, 3'b001, 1'b1, 1'b0);
    step();
    chk("cap_aluctrl", 32'(ALUctrl), 32'd1);
    chk("cap_op1", ALUop1, 32'd7);
    chk("cap_op2", ALUop2, 32'd3);
    chk("cap_valid", 32'(ex_valid), 32'd1);
    chk("cap_rd", 32'(ex_rd_addr), 32'd10);
    chk("cap_regwrite", 32'(ex_reg_write), 32'd1);
    chk("cap_no_stall", 32'(hazard_stall), 32'd0);

    // Bypass priority and x0 filtering: EX rs1=x5, rs2=x0
    set_id(1'b1, 5'd5, 5'd0, 5'd0, 32'h11, 32'h22, 32'h0, 1'b0, 3'b011, 1'b0, 1'b0);
    step();
    id_valid = 1'b0;
    mem_rd_addr = 5'd5; mem_reg_write = 1'b1; mem_result = 32'hAA;
    wb_rd_addr = 5'd5;  wb_reg_write = 1'b1;  wb_result = 32'hBB;
    #1;
    chk("prio_mem", ALUop1, FWD ? 32'hAA : 32'h11);
    mem_reg_write = 1'b0;
    #1;
    chk("prio_wb", ALUop1, FWD ? 32'hBB : 32'h11);
    mem_rd_addr = 5'd0; mem_reg_write = 1'b1; mem_result = 32'hFF;
    wb_reg_write = 1'b0;
    #1;
    chk("x0_op2", ALUop2, 32'h22);
    chk("x0_store", ex_store_data, 32'h22);

    // Immediate select: ALUop2 = imm, store data still rs2
    clr_bypass();
    set_id(1'b1, 5'd1, 5'd2, 5'd0, 32'h1, 32'h5678, 32'h1234, 1'b1, 3'b000, 1'b0, 1'b0);
    step();
    chk("imm_op2", ALUop2, 32'h1234);
    chk("imm_store", ex_store_data, 32'h5678);

    // Load-use: lw x6 in EX, consumer reads x6
    set_id(1'b1, 5'd1, 5'd2, 5'd6, 32'h0, 32'h0, 32'h10, 1'b1, 3'b000, 1'b1, 1'b1);
    step();
    chk("lw_memread", 32'(ex_mem_read), 32'd1);
    set_id(1'b1, 5'd6, 5'd7, 5'd8, 32'h99, 32'h5, 32'h0, 1'b0, 3'b010, 1'b1, 1'b0);
    #1;
    chk("lu_stall", 32'(hazard_stall), 32'd1);
    step();
    chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
    chk("lu_bubble_ctrl", 32'(ALUctrl), 32'd0);
    chk("lu_stall_drop", 32'(hazard_stall), 32'd0);
    mem_rd_addr = 5'd6; mem_reg_write = 1'b1; mem_result = 32'hCAFE;
    step();
    chk("lu_reissue_valid", 32'(ex_valid), 32'd1);
    chk("lu_reissue_ctrl", 32'(ALUctrl), 32'd2);
    chk("lu_fwd_op1", ALUop1, FWD ? 32'hCAFE : 32'h99);

    // Flush together with load-use stall
    clr_bypass();
    set_id(1'b1, 5'd1, 5'd2, 5'd9, 32'h0, 32'h0, 32'h4, 1'b1, 3'b000, 1'b1, 1'b1);
    step();
    set_id(1'b1, 5'd9, 5'd3, 5'd4, 32'h1, 32'h2, 32'h0, 1'b0, 3'b000, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    chk("flush_stall", 32'(hazard_stall), 32'd1);
    step();
    chk("flush_valid", 32'(ex_valid), 32'd0);
    chk("flush_regwrite", 32'(ex_reg_write), 32'd0);
    flush = 1'b0;

    // Non-load writer of x3 in EX, consumer reads x3
    set_id(1'b1, 5'd3, 5'd1, 5'd3, 32'h33, 32'h0, 32'h0, 1'b0, 3'b000, 1'b1, 1'b0);
    step();
    set_id(1'b1, 5'd3, 5'd1, 5'd12, 32'h44, 32'h0, 32'h0, 1'b0, 3'b011, 1'b1, 1'b0);
    mem_rd_addr = 5'd3; mem_reg_write = 1'b1; mem_result = 32'hDEAD;
    #1;
    chk("raw_stall", 32'(hazard_stall), FWD ? 32'd0 : 32'd1);
    chk("raw_op1", ALUop1, FWD ? 32'hDEAD : 32'h33);
    step();
    chk("raw_next_valid", 32'(ex_valid), FWD ? 32'd1 : 32'd0);
    clr_bypass();

    // Async reset in the middle of a load-use stall
    set_id(1'b1, 5'd1, 5'd2, 5'd11, 32'h5, 32'h6, 32'h0, 1'b0, 3'b000, 1'b1, 1'b1);
    step();
    set_id(1'b1, 5'd11, 5'd2, 5'd13, 32'h7, 32'h8, 32'h0, 1'b0, 3'b000, 1'b1, 1'b0);
    #1;
    chk("mid_stall_on", 32'(hazard_stall), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_stall", 32'(hazard_stall), 32'd0);
    chk("mid_rst_valid", 32'(ex_valid), 32'd0);
    chk("mid_rst_op1", ALUop1, 32'd0);
    step();
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register and operand-select stage directly upstream of the ALU. Captures decoded operands and control each cycle, then drives ALUctrl/ALUop1/ALUop2 with MEM- and WB-stage results forwarded in as needed. Detects load-use hazards, inserts bubbles, and supports flush on branch redirect.

## Interface
- D_WIDTH, 32, datapath width
- A_WIDTH, 5, register address width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  decode slot holds a real instruction
- id_rs1_addr, id_rs2_addr, id_rd_addr  in  A_WIDTH each  decoded register addresses
- id_rs1_data, id_rs2_data  in  D_WIDTH each  register-file read data
- id_imm  in  D_WIDTH  sign-extended immediate
- id_alu_src  in  1  1: ALUop2 takes the immediate
- id_alu_ctrl  in  3  ALU opcode (000 add, 001 sub, 010 and, 011 or, 100 sltu)
- id_reg_write, id_mem_read  in  1 each  writeback enable; load
- flush  in  1  squash the instruction entering EX
- mem_rd_addr  in  A_WIDTH; mem_reg_write  in  1; mem_result  in  D_WIDTH  EX/MEM bypass source
- wb_rd_addr  in  A_WIDTH; wb_reg_write  in  1; wb_result  in  D_WIDTH  MEM/WB bypass source
- ALUctrl  out  3; ALUop1, ALUop2  out  D_WIDTH  ALU operands
- ex_store_data  out  D_WIDTH  forwarded rs2 value for stores
- ex_valid, ex_reg_write, ex_mem_read  out  1 each; ex_rd_addr  out  A_WIDTH
- hazard_stall  out  1  stall PC and IF/ID this cycle

## Operation
- Stage register fields: valid, rs1/rs2/rd addr, rs1/rs2 data, imm, alu_src, alu_ctrl, reg_write, mem_read.
- hazard_stall (combinational) = ex_valid & ex_mem_read & ex_rd_addr≠0 & id_valid & (ex_rd_addr==id_rs1_addr | ex_rd_addr==id_rs2_addr). Both sources are compared unconditionally (conservative).
- Per-edge update, in priority order:
  - rst: all fields 0.
  - flush: all fields 0 (bubble).
  - hazard_stall: all fields 0 (bubble). The upstream stages hold the stalled instruction.
  - otherwise: capture the id_* inputs.
- Bubble = all-zero fields. It therefore presents as add x0,x0,x0 with reg_write=0.
- Forwarded rs1 (fwd1), combinational:
  - mem_result if mem_reg_write & mem_rd_addr≠0 & mem_rd_addr==ex rs1 addr;
  - else wb_result if wb_reg_write & wb_rd_addr≠0 & wb_rd_addr==ex rs1 addr;
  - else the registered rs1 data.
- fwd2 follows the same rule using rs2. MEM always has priority over WB. x0 is never forwarded.
- ALUop1 = fwd1. ALUop2 = alu_src ? imm : fwd2. ex_store_data = fwd2. ALUctrl = registered alu_ctrl.
- All arithmetic lives in the ALU. This block only selects and forwards, with no width change.

## Timing
- All outputs read 0 while rst is high and immediately after it, asynchronously. hazard_stall = 0 because ex_valid = 0.
- Latency: id_* captured at edge N appear on the outputs during cycle N+1.
- Forwarding is zero-latency. Changes on mem_*/wb_* affect ALUop1/ALUop2/ex_store_data within the same cycle.
- hazard_stall is asserted for exactly one cycle per load-use pair. The next cycle the load sits in MEM and is forwarded from mem_result.
- flush together with hazard_stall: a bubble is inserted and hazard_stall is still driven. Upstream gives flush priority.
- Reset asserted mid-stall clears the stage immediately; hazard_stall drops the same cycle.
- Registered valid=0 always yields ex_reg_write=0 and ex_mem_read=0.

## Configuration
- FORWARDING_EN defined: bypass muxes as above.
- FORWARDING_EN undefined:
  - fwd1/fwd2 are the registered rs1/rs2 data; mem_*/wb_* inputs are ignored.
  - hazard_stall also asserts when ex_valid & ex_reg_write & ex_rd_addr≠0 matches either id source (RAW stall on every dependency).
  - The stall persists cycle by cycle while any match holds.

## Test plan
- Reset: assert rst with id_valid=1 and random id_* → all outputs 0; after release, capture id_alu_ctrl=001, rs1_data=7, rs2_data=3 → next cycle ALUctrl=001, ALUop1=7, ALUop2=3.
- Priority: ex rs1=5 with mem_rd=5/mem_result=0xAA and wb_rd=5/wb_result=0xBB, both writes enabled → ALUop1=0xAA; drop mem_reg_write → 0xBB.
- x0: ex rs2=0, mem_rd=0, mem_reg_write=1, mem_result=0xFF, alu_src=0 → ALUop2 = registered rs2 data, not 0xFF.
- Load-use: EX holds lw to x6, ID reads x6 → hazard_stall=1 for one cycle, next cycle ex_valid=0 and ALUctrl=0; the re-presented instruction then gets ALUop1 = mem_result.
- Flush with stall: flush=1 and a load-use hazard together → bubble (ex_valid=0, ex_reg_write=0) and hazard_stall=1 in that cycle.
- FORWARDING_EN off: EX writes x3 (non-load), ID reads x3 → hazard_stall=1; mem_result is never seen on ALUop1.
